// File: rtl/stack_access_arbiter.sv
// -----------------------------------------------------------------------------
// stack_access_arbiter
//
// Shares a single LIFO stack core between two requesters. Requests are
// arbitrated round-robin. One operation is in flight at a time. The core is
// driven with single-cycle push/pop command pulses. The block keeps its own
// copy of the fill level, so a push when full or a pop when empty is rejected
// without touching the core. A WAIT-state watchdog converts a core that never
// answers into an error response and raises a sticky flag.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_valid[1:0]      per-requester pending operation, held until its ack
//   req_op[1:0]         per-requester operation: 0 = push, 1 = pop
//   req_wdata           push data, requester i in [i*DATA_W +: DATA_W]
//   req_ack[1:0]        one-cycle completion strobe to the granted requester
//   rsp_data            popped word while req_ack is high, 0 otherwise
//   rsp_err             high with req_ack for a rejected or timed-out operation
//   stk_push, stk_pop   one-cycle command pulses to the stack core
//   stk_wdata           push data towards the core
//   stk_rdata, stk_done core read data and completion pulse
//   level, full, empty  current fill level and its derived flags
//   timeout_seen        sticky, set on any core timeout
// -----------------------------------------------------------------------------
module stack_access_arbiter #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LVL_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ack,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_W-1:0]     stk_wdata,
  input  logic [DATA_W-1:0]     stk_rdata,
  input  logic                  stk_done,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  empty,
  output logic                  timeout_seen
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The watchdog fires on the WAIT cycle whose count is TIMEOUT-1, giving
  // exactly TIMEOUT WAIT cycles before the error response.
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic                grant;      // requester owning the current operation
  logic                last;       // most recent grant, for round-robin
  logic                op_lat;     // latched operation: 1 = pop
  logic [7:0]          wait_cnt;

  logic                grant_sel;
  logic                op_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic                illegal;
  logic                wait_expired;

  function automatic logic [1:0] ack_vec(input logic g);
    return {g, ~g};
  endfunction

  // Arbitration and legality of the candidate request seen in IDLE.
  always_comb begin
    grant_sel = 1'b0;
    if (req_valid == 2'b11) begin
      grant_sel = ~last;
    end else begin
      grant_sel = req_valid[1];
    end
    op_sel       = req_op[grant_sel];
    wdata_sel    = grant_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    illegal      = op_sel ? empty : full;
    wait_expired = (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = illegal ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (stk_done || wait_expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation context, level tracking and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= 1'b0;
      last         <= 1'b1;
      op_lat       <= 1'b0;
      stk_wdata    <= '0;
      wait_cnt     <= '0;
      level        <= '0;
      timeout_seen <= 1'b0;
      req_ack      <= '0;
      rsp_err      <= 1'b0;
      rsp_data     <= '0;
    end else begin
      // Response outputs are single-cycle; they only carry values in RESP.
      req_ack  <= '0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= grant_sel;
            last      <= grant_sel;
            op_lat    <= op_sel;
            stk_wdata <= wdata_sel;
            if (illegal) begin
              req_ack <= ack_vec(grant_sel);
              rsp_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          if (stk_done) begin
            req_ack <= ack_vec(grant);
            if (op_lat) begin
              level    <= level - LVL_ONE;
              rsp_data <= stk_rdata;
            end else begin
              level    <= level + LVL_ONE;
            end
          end else if (wait_expired) begin
            req_ack      <= ack_vec(grant);
            rsp_err      <= 1'b1;
            timeout_seen <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Command pulses are decoded from the state so they drop the moment
  // reset asserts.
  assign stk_push = (state == ISSUE) && !op_lat;
  assign stk_pop  = (state == ISSUE) &&  op_lat;
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);

endmodule

// File: tb/tb_stack_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_access_arbiter
//
// Drives two requesters and a behavioural stack core around the arbiter.
// Expected responses come from a reference model that holds the stack as a
// queue and schedules acks from the operation latencies (grant at cycle s,
// ack at s+1 when illegal, s+3+delay when the core answers, s+2+TIMEOUT
// when it does not).
// -----------------------------------------------------------------------------
module tb_stack_access_arbiter;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int LVL_W   = 5;
  localparam int TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_op = '0;
  logic [2*DATA_W-1:0] req_wdata = '0;
  logic [1:0]          req_ack;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic                stk_push;
  logic                stk_pop;
  logic [DATA_W-1:0]   stk_wdata;
  logic [DATA_W-1:0]   stk_rdata = '0;
  logic                stk_done = 1'b0;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                empty;
  logic                timeout_seen;

  stack_access_arbiter #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_done(stk_done),
    .level(level), .full(full), .empty(empty), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [7:0] d;
    int         dly;
    logic       hang;
  } op_t;

  int n_chk = 0;
  int n_err = 0;

  // Per-requester operation lists.
  op_t ops[2][0:511];
  int  head[2];
  int  tail[2];
  int  gap[2];
  int  gap_max;
  logic spur_en;

  // Reference model.
  logic [7:0] m_stk[$];
  logic       m_last;
  logic       m_to;
  logic       busy;
  logic       g;
  op_t        cur;
  logic       legal;
  int         start_cyc;
  int         ack_cyc;
  logic       e_err;
  logic [7:0] e_data;

  // Behavioural stack core.
  logic [7:0] core_mem[$];
  logic       core_pend;
  logic       core_pop;
  logic [7:0] core_wd;
  int         core_at;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_stk.delete();
    core_mem.delete();
    m_last    = 1'b1;
    m_to      = 1'b0;
    busy      = 1'b0;
    core_pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      head[i] = 0;
      tail[i] = 0;
      gap[i]  = 0;
    end
  endfunction

  function automatic void enq(input int r, input logic op, input logic [7:0] d,
                              input int dly, input logic hang);
    ops[r][tail[r]].op   = op;
    ops[r][tail[r]].d    = d;
    ops[r][tail[r]].dly  = dly;
    ops[r][tail[r]].hang = hang;
    tail[r]++;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_wdata = '0;
    stk_done  = 1'b0;
    stk_rdata = '0;
    @(posedge clk);
    #1;
    chk_eq("rst_req_ack", 32'(req_ack), 32'd0);
    chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk_eq("rst_stk_push", 32'(stk_push), 32'd0);
    chk_eq("rst_stk_pop", 32'(stk_pop), 32'd0);
    chk_eq("rst_stk_wdata", 32'(stk_wdata), 32'd0);
    chk_eq("rst_level", 32'(level), 32'd0);
    chk_eq("rst_empty", 32'(empty), 32'd1);
    chk_eq("rst_full", 32'(full), 32'd0);
    chk_eq("rst_timeout_seen", 32'(timeout_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // Runs every queued operation to completion, one clock per iteration.
  task automatic run_engine(input int budget);
    int         cyc;
    logic       ack_now;
    logic       pulse_now;
    logic [1:0] exp_ack;
    logic [7:0] tmp;
    cyc = 0;
    while ((head[0] != tail[0] || head[1] != tail[1] || busy) && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      ack_now   = busy && (cyc == ack_cyc);
      pulse_now = busy && legal && (cyc == start_cyc + 1);
      exp_ack   = ack_now ? (g ? 2'b10 : 2'b01) : 2'b00;
      if (ack_now && legal) begin
        if (cur.hang) m_to = 1'b1;
        else if (cur.op) tmp = m_stk.pop_back();
        else m_stk.push_back(cur.d);
      end
      chk_eq("stk_push", 32'(stk_push), 32'(pulse_now && !cur.op));
      chk_eq("stk_pop", 32'(stk_pop), 32'(pulse_now && cur.op));
      if (busy && legal && !cur.op && cyc > start_cyc && cyc < ack_cyc)
        chk_eq("stk_wdata", 32'(stk_wdata), 32'(cur.d));
      chk_eq("req_ack", 32'(req_ack), 32'(exp_ack));
      chk_eq("rsp_err", 32'(rsp_err), 32'(ack_now && e_err));
      chk_eq("rsp_data", 32'(rsp_data), ack_now ? 32'(e_data) : 32'd0);
      chk_eq("level", 32'(level), 32'(m_stk.size()));
      chk_eq("full", 32'(full), 32'(m_stk.size() == DEPTH));
      chk_eq("empty", 32'(empty), 32'(m_stk.size() == 0));
      chk_eq("timeout_seen", 32'(timeout_seen), 32'(m_to));

      // Core: reacts to the command pulses it actually sees.
      stk_done  = 1'b0;
      stk_rdata = 8'($urandom);
      if (ack_now) core_pend = 1'b0;
      if ((stk_push || stk_pop) && !core_pend) begin
        core_pend = 1'b1;
        core_pop  = stk_pop;
        core_wd   = stk_wdata;
        core_at   = (busy && !cur.hang) ? cyc + 1 + cur.dly : -1;
        // A done during the command cycle must be ignored by the arbiter.
        if (spur_en && $urandom_range(0, 3) == 0) stk_done = 1'b1;
      end else if (core_pend && cyc == core_at) begin
        stk_done  = 1'b1;
        core_pend = 1'b0;
        if (core_pop) begin
          if (core_mem.size() > 0) stk_rdata = core_mem.pop_back();
        end else begin
          core_mem.push_back(core_wd);
        end
      end

      // Requesters.
      if (ack_now) begin
        req_valid[g] = 1'b0;
        gap[g]       = int'($urandom_range(0, gap_max));
        head[g]++;
        busy         = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (busy && g == 1'(i)) begin
          req_op[i]              = 1'($urandom);
          req_wdata[i*DATA_W +: DATA_W] = 8'($urandom);
        end else if (!req_valid[i] && head[i] != tail[i] && !(ack_now && g == 1'(i))) begin
          if (gap[i] > 0) begin
            gap[i]--;
          end else begin
            req_valid[i]           = 1'b1;
            req_op[i]              = ops[i][head[i]].op;
            req_wdata[i*DATA_W +: DATA_W] = ops[i][head[i]].d;
          end
        end
      end

      // Arbitration by the round-robin rule.
      if (!busy && !ack_now && req_valid != 2'b00) begin
        if (req_valid == 2'b11) g = ~m_last;
        else g = req_valid[1];
        m_last    = g;
        cur       = ops[g][head[g]];
        busy      = 1'b1;
        start_cyc = cyc;
        legal     = cur.op ? (m_stk.size() > 0) : (m_stk.size() < DEPTH);
        if (!legal) begin
          ack_cyc = cyc + 1;
          e_err   = 1'b1;
          e_data  = 8'h00;
        end else if (cur.hang) begin
          ack_cyc = cyc + 2 + TIMEOUT;
          e_err   = 1'b1;
          e_data  = 8'h00;
        end else begin
          ack_cyc = cyc + 3 + cur.dly;
          e_err   = 1'b0;
          e_data  = cur.op ? m_stk[m_stk.size()-1] : 8'h00;
        end
      end
    end
    chk_eq("drain", 32'(busy || head[0] != tail[0] || head[1] != tail[1]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    gap_max = 0;
    spur_en = 1'b0;
    model_clear();

    // Single push, core answers one cycle after the pulse.
    do_reset();
    enq(0, 1'b0, 8'hA5, 0, 1'b0);
    run_engine(100);

    // Two pushes then a pop from the other requester.
    do_reset();
    enq(0, 1'b0, 8'h11, 1, 1'b0);
    enq(0, 1'b0, 8'h22, 2, 1'b0);
    run_engine(100);
    enq(1, 1'b1, 8'h00, 0, 1'b0);
    run_engine(100);

    // Both requesters contending: grants must alternate.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      enq(0, 1'b0, 8'(8'h30 + k), 0, 1'b0);
      enq(1, 1'b0, 8'(8'h40 + k), 1, 1'b0);
    end
    run_engine(200);

    // Fill to full, overflow, drain, underflow.
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) enq(0, 1'b0, 8'($urandom), k % 3, 1'b0);
    for (int k = 0; k < DEPTH + 1; k++) enq(1, 1'b1, 8'h00, k % 2, 1'b0);
    run_engine(600);

    // Core never answers, then a normal operation.
    do_reset();
    enq(0, 1'b0, 8'h3C, 0, 1'b1);
    enq(0, 1'b0, 8'h4D, 1, 1'b0);
    enq(1, 1'b1, 8'h00, 0, 1'b0);
    run_engine(200);

    // Randomized traffic from both requesters.
    do_reset();
    gap_max = 2;
    spur_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int   r;
      logic op;
      r  = int'($urandom_range(0, 1));
      op = (k < 150) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      enq(r, op, 8'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end
    run_engine(20000);
    gap_max = 0;
    spur_en = 1'b0;

    // Reset asserted while an operation sits in WAIT.
    do_reset();
    for (int k = 0; k < 3; k++) enq(0, 1'b0, 8'(8'h60 + k), 0, 1'b0);
    run_engine(100);
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    req_op    = 2'b00;
    req_wdata = 16'h005C;
    @(posedge clk);
    #1;
    chk_eq("rw_issue_push", 32'(stk_push), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_eq("rw_wait_ack", 32'(req_ack), 32'd0);
    chk_eq("rw_wait_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rw_async_level", 32'(level), 32'd0);
    chk_eq("rw_async_empty", 32'(empty), 32'd1);
    chk_eq("rw_async_push", 32'(stk_push), 32'd0);
    chk_eq("rw_async_wdata", 32'(stk_wdata), 32'd0);
    chk_eq("rw_async_ack", 32'(req_ack), 32'd0);
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_eq("rw_held_ack", 32'(req_ack), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    enq(0, 1'b0, 8'h77, 0, 1'b0);
    run_engine(100);
    chk_eq("rw_final_level", 32'(level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stack_access_arbiter.md
Name: stack_access_arbiter

Overview:
- Shares one 16-entry x 8-bit LIFO stack core between two requesters.
- Arbitrates push/pop requests round-robin and sequences the core with single-cycle command pulses.
- Tracks the fill level, so illegal operations (push when full, pop when empty) are rejected without touching the core.
- Sits between the chip-level command decode and the stack core; also reports level/full/empty and a sticky timeout flag.

Parameters:
- DATA_W, 8, stack word width.
- DEPTH, 16, stack entries; must match the stack core.
- LVL_W, 5, level counter width; must equal clog2(DEPTH+1).
- TIMEOUT, 15, maximum WAIT cycles before the core is declared hung; range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i = requester i has a pending operation; held until its ack.
- req_op  in  2  bit i: 0 = push, 1 = pop.
- req_wdata  in  2*DATA_W  requester i push data in bits [i*DATA_W +: DATA_W].
- req_ack  out  2  one-cycle completion strobe, one-hot to the granted requester.
- rsp_data  out  DATA_W  popped word; valid while req_ack is high, 0 otherwise.
- rsp_err  out  1  high with req_ack for a rejected or timed-out operation.
- stk_push  out  1  one-cycle push command to the stack core.
- stk_pop  out  1  one-cycle pop command to the stack core.
- stk_wdata  out  DATA_W  push data; stable from ISSUE until leaving WAIT.
- stk_rdata  in  DATA_W  core read data; sampled with stk_done on pops.
- stk_done  in  1  core completion pulse.
- level  out  LVL_W  current entry count, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- timeout_seen  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; req_ack, rsp_data, rsp_err, stk_push, stk_pop, stk_wdata, level, timeout_seen all 0.
  - Round-robin pointer last = 1.
  - Any in-flight operation is abandoned with no ack. The core shares rst_n, so level 0 stays consistent.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant one and latch grant, op, and wdata.
  - Arbitration: only one valid → grant it. Both valid → grant the requester != last. last updates on every grant, including rejected ones.
  - Check at grant: push with full=1 or pop with empty=1 is illegal → next state RESP with err=1. Otherwise → ISSUE.
- ISSUE (exactly 1 cycle):
  - stk_push or stk_pop is high per the latched op; the other stays 0.
  - stk_wdata = latched data.
  - Next state WAIT; the timeout counter clears to 0.
- WAIT:
  - stk_done is sampled only in this state; a stk_done during ISSUE is ignored.
  - On stk_done: push → level+1; pop → level-1 and rsp_data latched from stk_rdata. Next state RESP with err=0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT without done: next RESP with err=1, level unchanged, timeout_seen set.
- RESP (exactly 1 cycle):
  - req_ack[grant]=1; rsp_err and rsp_data are registered outputs. rsp_data = 0 for pushes and for errors.
  - Next state IDLE.
- Requester rule: req_valid[i] must drop on the edge that samples req_ack[i]=1. A requester may re-request starting the cycle after that.
- Latency, legal operation (request seen at edge 0):
  - ISSUE in cycle 1, WAIT from cycle 2.
  - With done in cycle k: ack in cycle k+1. Minimum 3 cycles, done in cycle 2.
- Latency, illegal operation: ack in cycle 1; no stk_push/stk_pop pulse.
- Throughput: one operation in flight at a time. The non-granted requester keeps req_valid high and wins the next IDLE arbitration.
- level saturation is impossible by construction; the legality check prevents over- and underflow.
- Changes to req_wdata or req_op after the grant edge have no effect.

Test Plan:
- Reset, then req0 push 0xA5 with core done 1 cycle after the pulse → stk_push high exactly in cycle 1, stk_wdata=0xA5, req_ack=01 in cycle 3, rsp_err=0, level=1, empty=0.
- Push 0x11, 0x22, then req1 pop, with core returning stk_rdata=0x22 → req_ack=10, rsp_data=0x22, level=1.
- req0 and req1 both valid from reset, each pushing, req0 repeating after its ack → grants alternate 0,1,0,1, and no requester waits more than one operation.
- 16 pushes → full=1, level=16; 17th push → ack in cycle 1, rsp_err=1, no stk_push pulse, level stays 16. Then from empty, a pop → rsp_err=1, rsp_data=0, no stk_pop pulse.
- Push with stk_done never asserted, TIMEOUT=15 → ack with rsp_err=1 exactly 15 WAIT cycles after ISSUE, timeout_seen=1 and sticky, level unchanged; the next legal operation completes normally.
- Reset asserted during WAIT → all outputs 0 immediately (asynchronous), no ack issued; after release a push succeeds and level=1.
